// File: rtl/meta_queue_guard.sv
// meta_queue_guard
//   Metadata stage behind the flow director. Every accepted entry is
//   range-checked: a PKT_PCIE entry whose pkt or dsc queue ID is out of range
//   is stored as PKT_DROP. Everything else, including both queue IDs, is
//   passed through unchanged. A 2-entry skid buffer decouples in_meta_ready
//   from out_meta_ready. Three saturating counters track forwarded PCIe
//   entries, forwarded drops and range rewrites.
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   in_meta_data/valid/ready upstream handshake (ready is a register)
//   out_meta_data/valid/ready downstream handshake (data = buffer head)
//   clear_stats              synchronous clear of all counters
//   stat_pcie_cnt/drop/oor   saturating statistics, CNT_W bits each

package meta_queue_guard_pkg;
   localparam logic [1:0] PKT_DROP = 2'd0;
   localparam logic [1:0] PKT_PCIE = 2'd1;
   localparam logic [1:0] PKT_ETH  = 2'd2;

   typedef struct packed {
      logic [15:0] pkt_queue_id;
      logic [15:0] dsc_queue_id;
      logic [1:0]  pkt_flags;
      logic [15:0] pkt_len;
   } metadata_t;
endpackage

module meta_queue_guard
   import meta_queue_guard_pkg::*;
#(
   parameter int unsigned NB_PKT_QUEUES = 8192,
   parameter int unsigned NB_DSC_QUEUES = 8192,
   parameter int unsigned CNT_W         = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  metadata_t        in_meta_data,
   input  logic             in_meta_valid,
   output logic             in_meta_ready,
   output metadata_t        out_meta_data,
   output logic             out_meta_valid,
   input  logic             out_meta_ready,
   input  logic             clear_stats,
   output logic [CNT_W-1:0] stat_pcie_cnt,
   output logic [CNT_W-1:0] stat_drop_cnt,
   output logic [CNT_W-1:0] stat_oor_cnt
);

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   state_t    state, state_nxt;
   metadata_t tail_q;
   metadata_t in_chk;
   logic      rdy_q;
   logic      accept, emit, oor;
   logic      pcie_inc, drop_inc;

   // Range check; the IDs are zero-extended so the compare is unsigned at full width.
   always_comb begin
      in_chk = in_meta_data;
      oor    = (in_meta_data.pkt_flags == PKT_PCIE) &&
               ((32'(in_meta_data.pkt_queue_id) >= NB_PKT_QUEUES) ||
                (32'(in_meta_data.dsc_queue_id) >= NB_DSC_QUEUES));
      if (oor) in_chk.pkt_flags = PKT_DROP;
   end

   assign in_meta_ready = rdy_q;
   assign accept        = in_meta_valid & rdy_q;
   assign emit          = out_meta_valid & out_meta_ready;

   always_comb begin
      state_nxt      = state;
      out_meta_valid = (state != EMPTY);
      case (state)
         EMPTY:   if (accept) state_nxt = ONE;
         ONE: begin
            if (accept && !emit)      state_nxt = FULL;
            else if (emit && !accept) state_nxt = EMPTY;
         end
         FULL:    if (emit) state_nxt = ONE;
         default: state_nxt = EMPTY;
      endcase
   end

   // Ready is registered from the next state so no combinational path
   // from out_meta_ready reaches in_meta_ready.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= EMPTY;
         rdy_q <= 1'b1;
      end else begin
         state <= state_nxt;
         rdy_q <= (state_nxt != FULL);
      end
   end

   // Head register is the output; tail only fills when the head is stalled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_meta_data <= '0;
         tail_q        <= '0;
      end else begin
         case (state)
            EMPTY: if (accept) out_meta_data <= in_chk;
            ONE: begin
               if (accept && emit) out_meta_data <= in_chk;
               else if (accept)    tail_q        <= in_chk;
            end
            FULL:  if (emit) out_meta_data <= tail_q;
            default: ;
         endcase
      end
   end

   assign pcie_inc = emit && (out_meta_data.pkt_flags == PKT_PCIE);
   assign drop_inc = emit && (out_meta_data.pkt_flags == PKT_DROP);

   // Clear wins over the old value but not over a same-cycle increment.
   function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                 input logic inc, input logic clr);
      if (clr)                 return CNT_W'(inc);
      else if (inc && c != '1) return c + 1'b1;
      else                     return c;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_pcie_cnt <= '0;
         stat_drop_cnt <= '0;
         stat_oor_cnt  <= '0;
      end else begin
         stat_pcie_cnt <= cnt_next(stat_pcie_cnt, pcie_inc, clear_stats);
         stat_drop_cnt <= cnt_next(stat_drop_cnt, drop_inc, clear_stats);
         stat_oor_cnt  <= cnt_next(stat_oor_cnt, accept && oor, clear_stats);
      end
   end

endmodule

// File: tb/tb_meta_queue_guard.sv
// Bench for meta_queue_guard: directed scenarios plus a random run, all
// checked against a queue-based reference model of the buffer and counters.
module tb_meta_queue_guard;
   import meta_queue_guard_pkg::*;

   localparam int CW = 4;
   localparam int unsigned NBQ = 8192;
   localparam int SAT = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   metadata_t     in_meta_data = '0;
   logic          in_meta_valid = 1'b0;
   logic          in_meta_ready;
   metadata_t     out_meta_data;
   logic          out_meta_valid;
   logic          out_meta_ready = 1'b0;
   logic          clear_stats = 1'b0;
   logic [CW-1:0] stat_pcie_cnt, stat_drop_cnt, stat_oor_cnt;

   meta_queue_guard #(.NB_PKT_QUEUES(NBQ), .NB_DSC_QUEUES(NBQ), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .in_meta_data(in_meta_data), .in_meta_valid(in_meta_valid), .in_meta_ready(in_meta_ready),
      .out_meta_data(out_meta_data), .out_meta_valid(out_meta_valid), .out_meta_ready(out_meta_ready),
      .clear_stats(clear_stats),
      .stat_pcie_cnt(stat_pcie_cnt), .stat_drop_cnt(stat_drop_cnt), .stat_oor_cnt(stat_oor_cnt)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: FIFO of stored entries (max 2) and integer counters.
   metadata_t mq[$];
   metadata_t emitted_q[$];
   int m_pcie = 0, m_drop = 0, m_oor = 0;

   function automatic metadata_t mk(int pq, int dq, logic [1:0] fl, int len);
      metadata_t m;
      m.pkt_queue_id = 16'(pq);
      m.dsc_queue_id = 16'(dq);
      m.pkt_flags    = fl;
      m.pkt_len      = 16'(len);
      return m;
   endfunction

   function automatic bit is_oor(metadata_t m);
      return m.pkt_flags == PKT_PCIE && (m.pkt_queue_id >= NBQ || m.dsc_queue_id >= NBQ);
   endfunction

   function automatic int sat(int c, bit inc, bit clr);
      if (clr) return inc ? 1 : 0;
      if (inc && c < SAT) return c + 1;
      return c;
   endfunction

   // Advance one clock, updating the model from the handshake as the model sees it.
   task automatic step();
      bit acc, emt;
      metadata_t st;
      @(negedge clk);
      acc = in_meta_valid && (mq.size() < 2);
      emt = out_meta_ready && (mq.size() > 0);
      st  = in_meta_data;
      if (is_oor(st)) st.pkt_flags = PKT_DROP;
      m_pcie = sat(m_pcie, emt && mq.size() > 0 && mq[0].pkt_flags == PKT_PCIE, clear_stats);
      m_drop = sat(m_drop, emt && mq.size() > 0 && mq[0].pkt_flags == PKT_DROP, clear_stats);
      m_oor  = sat(m_oor, acc && is_oor(in_meta_data), clear_stats);
      if (emt) begin
         emitted_q.push_back(out_meta_data);
         void'(mq.pop_front());
      end
      if (acc) mq.push_back(st);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      in_meta_valid  = 1'b0;
      out_meta_ready = 1'b1;
      clear_stats    = 1'b0;
      for (int i = 0; i < 4 && mq.size() > 0; i++) step();
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (out_meta_valid !== 1'b0 || in_meta_ready !== 1'b1 || out_meta_data !== '0) begin
         errors++;
         $display("FAIL reset_ctl: valid=%b ready=%b data=%h, want 0 1 0", out_meta_valid, in_meta_ready, out_meta_data);
      end
      checks++;
      if (stat_pcie_cnt !== '0 || stat_drop_cnt !== '0 || stat_oor_cnt !== '0) begin
         errors++;
         $display("FAIL reset_cnt: %0d %0d %0d, want 0 0 0", stat_pcie_cnt, stat_drop_cnt, stat_oor_cnt);
      end
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      metadata_t e = mk(5, 7, PKT_PCIE, 100);
      in_meta_data = e; in_meta_valid = 1'b1; out_meta_ready = 1'b1;
      step();
      in_meta_valid = 1'b0;
      checks++;
      if (out_meta_valid !== 1'b1 || out_meta_data !== e) begin
         errors++;
         $display("FAIL basic_out: valid=%b data=%h, want 1 %h", out_meta_valid, out_meta_data, e);
      end
      step();
      checks++;
      if (stat_pcie_cnt !== 4'd1 || out_meta_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_cnt: pcie=%0d valid=%b, want 1 0", stat_pcie_cnt, out_meta_valid);
      end
   endtask

   task automatic test_oor();
      metadata_t e = mk(8192, 7, PKT_PCIE, 33);
      metadata_t x = e;
      x.pkt_flags = PKT_DROP;
      in_meta_data = e; in_meta_valid = 1'b1; out_meta_ready = 1'b0;
      step();
      in_meta_valid = 1'b0;
      checks++;
      if (out_meta_data !== x || stat_oor_cnt !== 4'd1) begin
         errors++;
         $display("FAIL oor_rewrite: data=%h oor=%0d, want %h 1", out_meta_data, stat_oor_cnt, x);
      end
      out_meta_ready = 1'b1;
      step();
      checks++;
      if (stat_drop_cnt !== 4'd1 || stat_pcie_cnt !== 4'd1) begin
         errors++;
         $display("FAIL oor_drop_cnt: drop=%0d pcie=%0d, want 1 1", stat_drop_cnt, stat_pcie_cnt);
      end
      // Boundary: 8191/8191 is legal and stays PCIe.
      e = mk(8191, 8191, PKT_PCIE, 1);
      in_meta_data = e; in_meta_valid = 1'b1;
      step();
      in_meta_valid = 1'b0;
      checks++;
      if (out_meta_data !== e || stat_oor_cnt !== 4'd1) begin
         errors++;
         $display("FAIL oor_edge_legal: data=%h oor=%0d, want %h 1", out_meta_data, stat_oor_cnt, e);
      end
      drain();
   endtask

   task automatic test_drop_passthru();
      metadata_t e = mk(3, 9000, PKT_DROP, 77);
      in_meta_data = e; in_meta_valid = 1'b1; out_meta_ready = 1'b1;
      step();
      in_meta_valid = 1'b0;
      checks++;
      if (out_meta_data !== e || stat_oor_cnt !== 4'd1) begin
         errors++;
         $display("FAIL drop_pass: data=%h oor=%0d, want %h 1", out_meta_data, stat_oor_cnt, e);
      end
      drain();
      checks++;
      if (stat_drop_cnt !== 4'd2) begin
         errors++;
         $display("FAIL drop_pass_cnt: drop=%0d, want 2", stat_drop_cnt);
      end
   endtask

   task automatic test_backpressure();
      metadata_t e[3];
      int k = 0;
      int cyc = 0;
      bit acc;
      drain();
      emitted_q.delete();
      for (int i = 0; i < 3; i++) e[i] = mk(100 + i, 200 + i, PKT_PCIE, 64 + i);
      out_meta_ready = 1'b0; in_meta_valid = 1'b1; in_meta_data = e[0];
      for (int c = 0; c < 6; c++) begin
         acc = mq.size() < 2;
         step();
         if (acc) k++;
         in_meta_data = e[k];
         if (k == 2) begin
            checks++;
            if (in_meta_ready !== 1'b0 || out_meta_data !== e[0] || out_meta_valid !== 1'b1) begin
               errors++;
               $display("FAIL bp_stall: ready=%b valid=%b head=%h, want 0 1 %h", in_meta_ready, out_meta_valid, out_meta_data, e[0]);
            end
         end
      end
      out_meta_ready = 1'b1;
      while (emitted_q.size() < 3 && cyc < 10) begin
         acc = in_meta_valid && mq.size() < 2;
         step();
         cyc++;
         if (acc) begin k++; in_meta_valid = 1'b0; end
      end
      checks++;
      if (emitted_q.size() != 3 || cyc > 4) begin
         errors++;
         $display("FAIL bp_drain: emitted=%0d cycles=%0d, want 3 within 4", emitted_q.size(), cyc);
      end
      for (int i = 0; i < 3 && i < emitted_q.size(); i++) begin
         checks++;
         if (emitted_q[i] !== e[i]) begin
            errors++;
            $display("FAIL bp_order[%0d]: got %h want %h", i, emitted_q[i], e[i]);
         end
      end
   endtask

   task automatic test_random();
      int pq, dq;
      for (int c = 0; c < 400; c++) begin
         case ($urandom_range(0, 3))
            0: pq = 8191;
            1: pq = 8192;
            2: pq = $urandom_range(0, 65535);
            default: pq = $urandom_range(0, 20);
         endcase
         dq = ($urandom_range(0, 3) == 0) ? $urandom_range(8190, 8193) : $urandom_range(0, 65535);
         in_meta_data   = mk(pq, dq, 2'($urandom_range(0, 3)), $urandom_range(0, 65535));
         in_meta_valid  = ($urandom_range(0, 3) != 0);
         out_meta_ready = ($urandom_range(0, 2) != 0);
         clear_stats    = ($urandom_range(0, 40) == 0);
         step();
         checks++;
         if (out_meta_valid !== (mq.size() != 0) || in_meta_ready !== (mq.size() < 2)) begin
            errors++;
            $display("FAIL rnd_ctl @%0d: valid=%b ready=%b, model depth=%0d", c, out_meta_valid, in_meta_ready, mq.size());
         end
         if (mq.size() != 0) begin
            checks++;
            if (out_meta_data !== mq[0]) begin
               errors++;
               $display("FAIL rnd_data @%0d: got %h want %h", c, out_meta_data, mq[0]);
            end
         end
         checks++;
         if (stat_pcie_cnt !== CW'(m_pcie) || stat_drop_cnt !== CW'(m_drop) || stat_oor_cnt !== CW'(m_oor)) begin
            errors++;
            $display("FAIL rnd_cnt @%0d: got %0d %0d %0d want %0d %0d %0d", c,
                     stat_pcie_cnt, stat_drop_cnt, stat_oor_cnt, m_pcie, m_drop, m_oor);
         end
      end
      clear_stats = 1'b0;
   endtask

   task automatic test_saturate();
      drain();
      clear_stats = 1'b1;
      step();
      clear_stats = 1'b0;
      checks++;
      if (stat_pcie_cnt !== '0 || stat_drop_cnt !== '0 || stat_oor_cnt !== '0) begin
         errors++;
         $display("FAIL sat_clear: %0d %0d %0d, want 0 0 0", stat_pcie_cnt, stat_drop_cnt, stat_oor_cnt);
      end
      in_meta_valid = 1'b1; out_meta_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         in_meta_data = mk(i, i + 1, PKT_PCIE, i);
         step();
      end
      drain();
      checks++;
      if (stat_pcie_cnt !== 4'd15) begin
         errors++;
         $display("FAIL sat_pcie: got %0d want 15", stat_pcie_cnt);
      end
      in_meta_data = mk(1, 1, PKT_PCIE, 1); in_meta_valid = 1'b1;
      step();
      in_meta_valid = 1'b0; clear_stats = 1'b1;
      step();
      clear_stats = 1'b0;
      checks++;
      if (stat_pcie_cnt !== 4'd1) begin
         errors++;
         $display("FAIL sat_clear_inc: got %0d want 1", stat_pcie_cnt);
      end
      clear_stats = 1'b1;
      step();
      clear_stats = 1'b0;
      checks++;
      if (stat_pcie_cnt !== 4'd0) begin
         errors++;
         $display("FAIL sat_clear_only: got %0d want 0", stat_pcie_cnt);
      end
   endtask

   task automatic test_reset_full();
      drain();
      out_meta_ready = 1'b0; in_meta_valid = 1'b1;
      in_meta_data = mk(11, 12, PKT_PCIE, 5); step();
      in_meta_data = mk(13, 14, PKT_PCIE, 6); step();
      in_meta_valid = 1'b0;
      checks++;
      if (in_meta_ready !== 1'b0) begin
         errors++;
         $display("FAIL rstfull_pre: ready=%b want 0", in_meta_ready);
      end
      #2 rst = 1'b0;
      #1;
      mq.delete(); m_pcie = 0; m_drop = 0; m_oor = 0;
      checks++;
      if (out_meta_valid !== 1'b0 || in_meta_ready !== 1'b1) begin
         errors++;
         $display("FAIL rstfull_async: valid=%b ready=%b want 0 1", out_meta_valid, in_meta_ready);
      end
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      out_meta_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (out_meta_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstfull_stale @%0d: valid=%b data=%h", i, out_meta_valid, out_meta_data);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_oor();
      test_drop_passthru();
      test_backpressure();
      test_random();
      test_saturate();
      test_reset_full();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
